// File: rtl/sram_seg_arbiter.sv
// Arbitrates one segmented SRAM between the scan port (single segment) and the engine port (word as 8 segments).
// Latency: with a 1-cycle SRAM, scan ack 3 cycles and engine ack 17 cycles after the request is first seen idle.
// Backpressure: req held until ack; ties alternate round-robin, engine bursts are never preempted.
// Optional: define SRAM_ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYC cycles and set sticky arb_err.
module sram_seg_arbiter #(
    parameter int SEG_W       = 16,
    parameter int SEGS        = 8,
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 64,
    localparam int SEL_W      = $clog2(SEGS),
    localparam int WORD_W     = SEG_W * SEGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan_req,
    input  logic              scan_we,
    input  logic [ADDR_W-1:0] scan_addr,
    input  logic [SEL_W-1:0]  scan_seg,
    input  logic [SEG_W-1:0]  scan_wdata,
    output logic [SEG_W-1:0]  scan_rdata,
    output logic              scan_ack,
    input  logic              eng_req,
    input  logic              eng_we,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [WORD_W-1:0] eng_wdata,
    output logic [WORD_W-1:0] eng_rdata,
    output logic              eng_ack,
    output logic              sram_ren,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [SEL_W-1:0]  sram_seg_sel,
    output logic [SEG_W-1:0]  sram_wdata,
    input  logic [SEG_W-1:0]  sram_rdata,
    input  logic              sram_ready,
    output logic              busy,
    output logic              grant_eng,
    output logic              arb_err
);

    typedef enum logic [2:0] {
        IDLE, SCAN_ISSUE, SCAN_WAIT, ENG_ISSUE, ENG_WAIT, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    seg_cnt_q, seg_cnt_d;
    logic                last_eng_q, last_eng_d;   // 1 = engine received the most recent grant
    logic                owner_eng_q, owner_eng_d; // owner of the access in flight
    logic                req_we_q, req_we_d;
    logic [WORD_W-1:0]   eng_wdata_q, eng_wdata_d;
    logic                sram_ren_q, sram_ren_d;
    logic                sram_wen_q, sram_wen_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic [SEL_W-1:0]    sram_seg_sel_q, sram_seg_sel_d;
    logic [SEG_W-1:0]    sram_wdata_q, sram_wdata_d;
    logic [SEG_W-1:0]    scan_rdata_q, scan_rdata_d;
    logic [WORD_W-1:0]   eng_rdata_q, eng_rdata_d;
    logic                scan_ack_q, scan_ack_d;
    logic                eng_ack_q, eng_ack_d;
    logic                busy_q, busy_d;
    logic                grant_eng_q, grant_eng_d;
    logic                pick_scan;
    logic [SEL_W-1:0]    next_seg;

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC) + 1;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                arb_err_q, arb_err_d;
`endif

    // Next-state, strobe and capture logic; every output is registered from here
    always_comb begin
        state_d        = state_q;
        seg_cnt_d      = seg_cnt_q;
        last_eng_d     = last_eng_q;
        owner_eng_d    = owner_eng_q;
        req_we_d       = req_we_q;
        eng_wdata_d    = eng_wdata_q;
        sram_ren_d     = 1'b0;
        sram_wen_d     = 1'b0;
        sram_addr_d    = sram_addr_q;
        sram_seg_sel_d = sram_seg_sel_q;
        sram_wdata_d   = sram_wdata_q;
        scan_rdata_d   = scan_rdata_q;
        eng_rdata_d    = eng_rdata_q;
        scan_ack_d     = 1'b0;
        eng_ack_d      = 1'b0;
        // Scan wins unless the engine also asks and scan had the last grant
        pick_scan      = scan_req && (!eng_req || last_eng_q);
        next_seg       = seg_cnt_q + 1'b1;
`ifdef SRAM_ARB_TIMEOUT_EN
        wait_cnt_d     = wait_cnt_q;
        arb_err_d      = arb_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_scan) begin
                    state_d        = SCAN_ISSUE;
                    owner_eng_d    = 1'b0;
                    last_eng_d     = 1'b0;
                    req_we_d       = scan_we;
                    sram_ren_d     = !scan_we;
                    sram_wen_d     = scan_we;
                    sram_addr_d    = scan_addr;
                    sram_seg_sel_d = scan_seg;
                    sram_wdata_d   = scan_wdata;
                end else if (eng_req) begin
                    state_d        = ENG_ISSUE;
                    seg_cnt_d      = '0;
                    owner_eng_d    = 1'b1;
                    last_eng_d     = 1'b1;
                    req_we_d       = eng_we;
                    eng_wdata_d    = eng_wdata;
                    sram_ren_d     = !eng_we;
                    sram_wen_d     = eng_we;
                    sram_addr_d    = eng_addr;
                    sram_seg_sel_d = '0;
                    sram_wdata_d   = eng_wdata[SEG_W-1:0];
                end
            end
            SCAN_ISSUE: state_d = SCAN_WAIT;
            SCAN_WAIT: begin
                if (sram_ready) begin
                    if (!req_we_q) scan_rdata_d = sram_rdata;
                    scan_ack_d = 1'b1;
                    state_d    = DONE;
                end
            end
            ENG_ISSUE: state_d = ENG_WAIT;
            ENG_WAIT: begin
                if (sram_ready) begin
                    if (!req_we_q) eng_rdata_d[int'(seg_cnt_q)*SEG_W +: SEG_W] = sram_rdata;
                    if (seg_cnt_q == SEL_W'(SEGS-1)) begin
                        eng_ack_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        // Re-issue the next segment straight from the word latched at grant
                        seg_cnt_d      = next_seg;
                        state_d        = ENG_ISSUE;
                        sram_ren_d     = !req_we_q;
                        sram_wen_d     = req_we_q;
                        sram_seg_sel_d = next_seg;
                        sram_wdata_d   = eng_wdata_q[int'(next_seg)*SEG_W +: SEG_W];
                    end
                end
            end
            DONE: begin
                state_d   = IDLE;
                seg_cnt_d = '0;
            end
            default: state_d = IDLE;
        endcase
`ifdef SRAM_ARB_TIMEOUT_EN
        // Wait counter: cleared by each issue, aborts the access when the SRAM never answers
        if (state_q == SCAN_ISSUE || state_q == ENG_ISSUE) begin
            wait_cnt_d = '0;
        end else if ((state_q == SCAN_WAIT || state_q == ENG_WAIT) && !sram_ready) begin
            if (wait_cnt_q == WAIT_W'(TIMEOUT_CYC-1)) begin
                state_d    = DONE;
                arb_err_d  = 1'b1;
                scan_ack_d = !owner_eng_q;
                eng_ack_d  = owner_eng_q;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
`endif
        busy_d      = (state_d != IDLE);
        grant_eng_d = (state_d == ENG_ISSUE) || (state_d == ENG_WAIT) ||
                      ((state_d == DONE) && owner_eng_d);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            seg_cnt_q      <= '0;
            last_eng_q     <= 1'b1;
            owner_eng_q    <= 1'b0;
            req_we_q       <= 1'b0;
            eng_wdata_q    <= '0;
            sram_ren_q     <= 1'b0;
            sram_wen_q     <= 1'b0;
            sram_addr_q    <= '0;
            sram_seg_sel_q <= '0;
            sram_wdata_q   <= '0;
            scan_rdata_q   <= '0;
            eng_rdata_q    <= '0;
            scan_ack_q     <= 1'b0;
            eng_ack_q      <= 1'b0;
            busy_q         <= 1'b0;
            grant_eng_q    <= 1'b0;
`ifdef SRAM_ARB_TIMEOUT_EN
            wait_cnt_q     <= '0;
            arb_err_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            seg_cnt_q      <= seg_cnt_d;
            last_eng_q     <= last_eng_d;
            owner_eng_q    <= owner_eng_d;
            req_we_q       <= req_we_d;
            eng_wdata_q    <= eng_wdata_d;
            sram_ren_q     <= sram_ren_d;
            sram_wen_q     <= sram_wen_d;
            sram_addr_q    <= sram_addr_d;
            sram_seg_sel_q <= sram_seg_sel_d;
            sram_wdata_q   <= sram_wdata_d;
            scan_rdata_q   <= scan_rdata_d;
            eng_rdata_q    <= eng_rdata_d;
            scan_ack_q     <= scan_ack_d;
            eng_ack_q      <= eng_ack_d;
            busy_q         <= busy_d;
            grant_eng_q    <= grant_eng_d;
`ifdef SRAM_ARB_TIMEOUT_EN
            wait_cnt_q     <= wait_cnt_d;
            arb_err_q      <= arb_err_d;
`endif
        end
    end

    assign sram_ren     = sram_ren_q;
    assign sram_wen     = sram_wen_q;
    assign sram_addr    = sram_addr_q;
    assign sram_seg_sel = sram_seg_sel_q;
    assign sram_wdata   = sram_wdata_q;
    assign scan_rdata   = scan_rdata_q;
    assign eng_rdata    = eng_rdata_q;
    assign scan_ack     = scan_ack_q;
    assign eng_ack      = eng_ack_q;
    assign busy         = busy_q;
    assign grant_eng    = grant_eng_q;
`ifdef SRAM_ARB_TIMEOUT_EN
    assign arb_err      = arb_err_q;
`else
    assign arb_err      = 1'b0;
`endif

endmodule

// File: tb/tb_sram_seg_arbiter.sv
// Bench for sram_seg_arbiter: behavioural SRAM, reference memory, per-port expected-ack scoreboards.
// Latency: checked against the nominal request-to-ack cycle counts where the schedule is known.
// Backpressure: requesters hold req until ack; SRAM ready delay is randomised in the random phase.
module tb_sram_seg_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         scan_req, scan_we;
    logic [3:0]   scan_addr;
    logic [2:0]   scan_seg;
    logic [15:0]  scan_wdata, scan_rdata;
    logic         scan_ack;
    logic         eng_req, eng_we;
    logic [3:0]   eng_addr;
    logic [127:0] eng_wdata, eng_rdata;
    logic         eng_ack;
    logic         sram_ren, sram_wen;
    logic [3:0]   sram_addr;
    logic [2:0]   sram_seg_sel;
    logic [15:0]  sram_wdata, sram_rdata;
    logic         sram_ready;
    logic         busy, grant_eng, arb_err;

    sram_seg_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .scan_req(scan_req), .scan_we(scan_we), .scan_addr(scan_addr), .scan_seg(scan_seg),
        .scan_wdata(scan_wdata), .scan_rdata(scan_rdata), .scan_ack(scan_ack),
        .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
        .eng_rdata(eng_rdata), .eng_ack(eng_ack),
        .sram_ren(sram_ren), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_seg_sel(sram_seg_sel), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_ready(sram_ready), .busy(busy), .grant_eng(grant_eng), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [127:0] data;
        int           req_cyc;
        int           lat;
    } exp_t;
    exp_t scan_q[$];
    exp_t eng_q[$];

    // Reference contents and the value each rdata port should be holding
    logic [15:0]  ref_mem [16][8];
    logic [15:0]  last_scan_rd;
    logic [127:0] last_eng_rd;

    // Fields of the operation each requester currently has outstanding
    bit           cur_scan_we, cur_eng_we;
    int           cur_scan_addr, cur_scan_seg, cur_eng_addr;
    logic [15:0]  cur_scan_wdata;
    logic [127:0] cur_eng_word;

    // Behavioural SRAM: ready arrives one cycle after the strobe plus an optional random delay
    logic [15:0]  mem [16][8];
    bit           sram_mute = 0;
    bit           rand_lat = 0;
    bit           pend = 0;
    int           pend_cnt = 0;
    logic [15:0]  pend_data;
    bit           prev_strobe = 0;
    int           eng_seg_exp = 0;
    int           scan_strobe_cnt = 0, eng_strobe_cnt = 0;
    int           scan_wr_strobes = 0, eng_wr_strobes = 0;
    int           last_scan_strobe_cyc = -1;
    int           last_eng_ack_cyc = -1;
    int           eng_ack_cnt = 0;

    always @(negedge clk) begin
        sram_ready = 1'b0;
        if (!rst_n) begin
            pend = 0;
            prev_strobe = 0;
            eng_seg_exp = 0;
        end else begin
            if (pend) begin
                if (pend_cnt == 0) begin
                    sram_ready = 1'b1;
                    sram_rdata = pend_data;
                    pend = 0;
                end else begin
                    pend_cnt--;
                end
            end
            if (sram_ren || sram_wen) begin
                chk("strobe_onehot", 128'(sram_ren ^ sram_wen), 128'(1));
                chk("strobe_single_cycle", 128'(prev_strobe), 128'(0));
                if (grant_eng) begin
                    chk("eng_seg_order", 128'(sram_seg_sel), 128'(eng_seg_exp));
                    chk("eng_addr", 128'(sram_addr), 128'(cur_eng_addr));
                    chk("eng_dir", 128'(sram_wen), 128'(cur_eng_we));
                    if (sram_wen) begin
                        chk("eng_wdata_seg", 128'(sram_wdata), 128'(cur_eng_word[eng_seg_exp*16 +: 16]));
                        eng_wr_strobes++;
                    end
                    eng_seg_exp = (eng_seg_exp + 1) % 8;
                    eng_strobe_cnt++;
                end else begin
                    chk("scan_addr", 128'(sram_addr), 128'(cur_scan_addr));
                    chk("scan_seg", 128'(sram_seg_sel), 128'(cur_scan_seg));
                    chk("scan_dir", 128'(sram_wen), 128'(cur_scan_we));
                    if (sram_wen) begin
                        chk("scan_wdata", 128'(sram_wdata), 128'(cur_scan_wdata));
                        scan_wr_strobes++;
                    end
                    last_scan_strobe_cyc = cyc;
                    scan_strobe_cnt++;
                end
                if (!sram_mute) begin
                    if (sram_wen) mem[sram_addr][sram_seg_sel] = sram_wdata;
                    pend_data = mem[sram_addr][sram_seg_sel];
                    pend = 1;
                    pend_cnt = rand_lat ? int'($urandom_range(0, 2)) : 0;
                end
            end
            prev_strobe = sram_ren || sram_wen;
        end
    end

    // Monitor: every ack must match the oldest expectation of its port
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (scan_ack) begin
                chk("scan_ack_pending", 128'(scan_q.size() > 0), 128'(1));
                if (scan_q.size() > 0) begin
                    e = scan_q.pop_front();
                    chk("scan_rdata", 128'(scan_rdata), e.data);
                    if (e.lat >= 0) chk("scan_latency", 128'(cyc - e.req_cyc), 128'(e.lat));
                end
            end
            if (eng_ack) begin
                eng_ack_cnt++;
                last_eng_ack_cyc = cyc;
                chk("eng_ack_pending", 128'(eng_q.size() > 0), 128'(1));
                if (eng_q.size() > 0) begin
                    e = eng_q.pop_front();
                    chk("eng_rdata", eng_rdata, e.data);
                    if (e.lat >= 0) chk("eng_latency", 128'(cyc - e.req_cyc), 128'(e.lat));
                end
            end
        end
    end

    task automatic scan_op(input bit we, input int addr, input int seg, input logic [15:0] d,
                           input int lat, input bit aborts);
        exp_t e;
        int   start;
        bit   seen;
        @(negedge clk);
        cur_scan_we = we; cur_scan_addr = addr; cur_scan_seg = seg; cur_scan_wdata = d;
        e.data = '0;
        if (!aborts && we) ref_mem[addr][seg] = d;
        else if (!aborts) last_scan_rd = ref_mem[addr][seg];
        e.data[15:0] = last_scan_rd;
        e.req_cyc = cyc;
        e.lat = lat;
        scan_q.push_back(e);
        scan_req = 1'b1; scan_we = we; scan_addr = 4'(addr); scan_seg = 3'(seg); scan_wdata = d;
        start = scan_strobe_cnt;
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (scan_ack) begin
                seen = 1;
                break;
            end
            // Once issued, the pins must no longer matter
            if (scan_strobe_cnt != start) begin
                scan_we = 1'($urandom); scan_addr = 4'($urandom);
                scan_seg = 3'($urandom); scan_wdata = 16'($urandom);
            end
        end
        scan_req = 1'b0;
        chk("scan_ack_seen", 128'(seen), 128'(1));
    endtask

    task automatic eng_op(input bit we, input int addr, input logic [127:0] w, input int lat);
        exp_t e;
        int   start;
        bit   seen;
        @(negedge clk);
        cur_eng_we = we; cur_eng_addr = addr; cur_eng_word = w;
        if (we) begin
            for (int k = 0; k < 8; k++) ref_mem[addr][k] = w[k*16 +: 16];
        end else begin
            for (int k = 0; k < 8; k++) last_eng_rd[k*16 +: 16] = ref_mem[addr][k];
        end
        e.data = last_eng_rd;
        e.req_cyc = cyc;
        e.lat = lat;
        eng_q.push_back(e);
        eng_req = 1'b1; eng_we = we; eng_addr = 4'(addr); eng_wdata = w;
        start = eng_strobe_cnt;
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (eng_ack) begin
                seen = 1;
                break;
            end
            if (eng_strobe_cnt != start) begin
                eng_we = 1'($urandom); eng_addr = 4'($urandom);
                eng_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        eng_req = 1'b0;
        chk("eng_ack_seen", 128'(seen), 128'(1));
    endtask

    task automatic chk_outputs_zero(input string name);
        chk(name, 128'({sram_ren, sram_wen, sram_addr, sram_seg_sel, sram_wdata, scan_rdata,
                        scan_ack, eng_ack, busy, grant_eng, arb_err}), 128'(0));
        chk({name, "_eng_rdata"}, eng_rdata, 128'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_outputs_zero("reset_outputs");
        rst_n = 1'b1;
        last_scan_rd = '0;
        last_eng_rd = '0;
    endtask

    logic [127:0] w;
    int           saved_acks;
    bit           reached;

    initial begin
        rst_n = 1'b0;
        scan_req = 0; scan_we = 0; scan_addr = '0; scan_seg = '0; scan_wdata = '0;
        eng_req = 0; eng_we = 0; eng_addr = '0; eng_wdata = '0;
        sram_ready = 0; sram_rdata = '0;
        for (int a = 0; a < 16; a++)
            for (int s = 0; s < 8; s++) begin
                mem[a][s] = '0;
                ref_mem[a][s] = '0;
            end
        do_reset();

        // Scan write then read back
        scan_op(1, 3, 5, 16'hBEEF, 3, 0);
        chk("scan_wr_strobes", 128'(scan_wr_strobes), 128'(1));
        chk("scan_done_grant_eng", 128'(grant_eng), 128'(0));
        scan_op(0, 3, 5, 16'h0, 3, 0);

        // Engine word write (segment k holds k) then read back
        for (int k = 0; k < 8; k++) w[k*16 +: 16] = 16'(k);
        eng_op(1, 9, w, 17);
        chk("eng_wr_strobes", 128'(eng_wr_strobes), 128'(8));
        chk("eng_done_grant_eng", 128'(grant_eng), 128'(1));
        chk("eng_done_busy", 128'(busy), 128'(1));
        @(negedge clk);
        chk("idle_busy", 128'(busy), 128'(0));
        chk("idle_grant_eng", 128'(grant_eng), 128'(0));
        eng_op(0, 9, '0, 17);

        // Ties after reset: scan first; after a lone scan grant the engine wins the tie
        do_reset();
        fork
            scan_op(1, 4, 2, 16'h5A5A, 3, 0);
            eng_op(1, 11, {$urandom, $urandom, $urandom, $urandom}, 21);
        join
        scan_op(0, 4, 2, 16'h0, 3, 0);
        fork
            eng_op(0, 11, '0, 17);
            scan_op(0, 4, 2, 16'h0, 21, 0);
        join

        // Scan raised mid-burst waits for the whole engine word
        fork
            eng_op(1, 10, {$urandom, $urandom, $urandom, $urandom}, 17);
            begin
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (eng_seg_exp == 4) break;
                end
                scan_op(0, 3, 5, 16'h0, -1, 0);
            end
        join
        chk("atomic_scan_after_eng", 128'(last_scan_strobe_cyc), 128'(last_eng_ack_cyc + 2));

        // Reset during segment 4 of an engine read
        @(negedge clk);
        cur_eng_we = 0; cur_eng_addr = 12; cur_eng_word = '0;
        eng_req = 1'b1; eng_we = 1'b0; eng_addr = 4'd12;
        saved_acks = eng_ack_cnt;
        reached = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (eng_seg_exp == 5) begin
                reached = 1;
                break;
            end
        end
        chk("rst_reached_seg4", 128'(reached), 128'(1));
        rst_n = 1'b0;
        eng_req = 1'b0;
        @(negedge clk);
        chk_outputs_zero("midburst_reset_outputs");
        rst_n = 1'b1;
        last_scan_rd = '0;
        last_eng_rd = '0;
        repeat (4) @(negedge clk);
        chk("rst_no_eng_ack", 128'(eng_ack_cnt), 128'(saved_acks));
        scan_op(0, 3, 5, 16'h0, 3, 0);

        // Random concurrent traffic on disjoint address halves with random SRAM delay
        rand_lat = 1;
        fork
            for (int n = 0; n < 30; n++) begin
                scan_op(1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                        16'($urandom), -1, 0);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            for (int n = 0; n < 8; n++) begin
                eng_op(1'($urandom), int'($urandom_range(8, 15)),
                       {$urandom, $urandom, $urandom, $urandom}, -1);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        join
        rand_lat = 0;
        repeat (4) @(negedge clk);
        chk("scan_q_drained", 128'(scan_q.size()), 128'(0));
        chk("eng_q_drained", 128'(eng_q.size()), 128'(0));

`ifdef SRAM_ARB_TIMEOUT_EN
        chk("arb_err_clear", 128'(arb_err), 128'(0));
        sram_mute = 1;
        scan_op(0, 5, 1, 16'h0, 66, 1);
        chk("timeout_arb_err", 128'(arb_err), 128'(1));
        @(negedge clk);
        chk("timeout_busy_after", 128'(busy), 128'(0));
        repeat (5) @(negedge clk);
        chk("timeout_arb_err_sticky", 128'(arb_err), 128'(1));
        sram_mute = 0;
`else
        chk("arb_err_tied", 128'(arb_err), 128'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_seg_arbiter.md
Name: sram_seg_arbiter

Overview:
- Shares the single segmented 128-bit SRAM (16 words x 8 segments x 16 bits) between two requesters.
  - Scan port: single 16-bit segment accesses from the scan chain.
  - Engine port: full 128-bit word accesses from the SIMD engine.
- Each engine access is sequenced internally as 8 segment accesses.
- Drives the SRAM ren/wen/addr/seg_sel/wdata interface and consumes its rdata/ready.

Parameters:
- SEG_W, 16, segment data width.
- SEGS, 8, segments per word; seg_sel width is log2(SEGS).
- ADDR_W, 4, word address width.
- TIMEOUT_CYC, 64, ready-wait limit in cycles; used only when SRAM_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- scan_req  in  1  scan access request; held until scan_ack.
- scan_we  in  1  1 = write, 0 = read.
- scan_addr  in  ADDR_W  word address.
- scan_seg  in  3  segment select.
- scan_wdata  in  SEG_W  write data.
- scan_rdata  out  SEG_W  read data; valid in the scan_ack cycle and held until the next scan read completes.
- scan_ack  out  1  one-cycle completion pulse.
- eng_req  in  1  engine word request; held until eng_ack.
- eng_we  in  1  1 = write, 0 = read.
- eng_addr  in  ADDR_W  word address.
- eng_wdata  in  SEG_W*SEGS  write word.
- eng_rdata  out  SEG_W*SEGS  read word; valid in the eng_ack cycle, held afterwards.
- eng_ack  out  1  one-cycle completion pulse.
- sram_ren  out  1  SRAM read strobe.
- sram_wen  out  1  SRAM write strobe.
- sram_addr  out  ADDR_W  SRAM word address.
- sram_seg_sel  out  3  SRAM segment select.
- sram_wdata  out  SEG_W  SRAM write data.
- sram_rdata  in  SEG_W  SRAM read data; valid when sram_ready = 1.
- sram_ready  in  1  SRAM completion pulse.
- busy  out  1  high in any state other than IDLE.
- grant_eng  out  1  1 while the engine owns the SRAM.
- arb_err  out  1  sticky timeout error; constant 0 without the optional feature.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - All outputs go to 0.
  - State = IDLE, seg_cnt = 0, last_grant = ENG, so scan wins the first tie.
  - Reset mid-operation aborts any burst with no ack. The SRAM may hold a partial engine write; this is accepted.
- FSM states: IDLE, SCAN_ISSUE, SCAN_WAIT, ENG_ISSUE, ENG_WAIT, DONE.
- IDLE:
  - Only scan_req pending: go to SCAN_ISSUE.
  - Only eng_req pending: go to ENG_ISSUE with seg_cnt = 0.
  - Both pending: grant the requester opposite to last_grant (round-robin), then update last_grant.
  - Request fields are latched on the grant edge. Later changes are ignored until ack.
- Issue states:
  - SCAN_ISSUE / ENG_ISSUE: assert exactly one of sram_ren or sram_wen for exactly one cycle.
  - sram_addr, sram_seg_sel and sram_wdata are valid in that cycle and held through the following WAIT.
  - ENG_ISSUE: sram_seg_sel = seg_cnt; sram_wdata = eng_wdata[seg_cnt*SEG_W +: SEG_W].
- SCAN_WAIT on sram_ready = 1:
  - Capture sram_rdata into scan_rdata (reads only).
  - Go to DONE, which pulses scan_ack next cycle.
- ENG_WAIT on sram_ready = 1:
  - Capture into eng_rdata[seg_cnt*SEG_W +: SEG_W] (reads only).
  - If seg_cnt = SEGS-1: go to DONE.
  - Otherwise: seg_cnt++ and return to ENG_ISSUE. Segments are always issued in order 0 to 7.
- DONE: pulse the owning requester's ack for one cycle, then return to IDLE. The next request can be granted in the following cycle.
- An engine burst is atomic: scan requests wait during all 8 segments and are never preempted.
- sram_ready outside a WAIT state is ignored.
- Latency with an SRAM whose ready arrives 1 cycle after the strobe, request first seen in IDLE at cycle 0:
  - Scan: strobe at cycle 1, ready at 2, ack at 3.
  - Engine: strobes at cycles 1, 3, ..., 15; ready at 16; ack at 17.
- busy is 0 only in IDLE. grant_eng is 1 in ENG_ISSUE, ENG_WAIT, and DONE-for-engine.

Optional Feature:
- Macro: SRAM_ARB_TIMEOUT_EN.
- Defined:
  - A wait counter clears on every ISSUE and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYC without sram_ready, go to DONE and ack the owner. The burst is aborted; eng_rdata keeps any partially captured segments.
  - arb_err is set and stays set until reset.
- Undefined:
  - WAIT states wait for sram_ready indefinitely.
  - arb_err is tied to 0 and no counter exists.

Test Plan:
- Scan write, then read: scan write addr 3, seg 5, data 0xBEEF, then scan read of the same location. Required: one sram_wen pulse with addr = 3, seg_sel = 5, wdata = 0xBEEF; read returns scan_rdata = 0xBEEF; with 1-cycle ready, scan_ack arrives 3 cycles after the request.
- Engine word write, then read: engine write addr 9, data 0x0007_0006_0005_0004_0003_0002_0001_0000 (segment k holds value k). Required: 8 sram_wen pulses with seg_sel 0..7 and wdata 0..7; engine read of addr 9 returns the same word; eng_ack at cycle 17.
- Simultaneous requests: scan_req and eng_req raised in the same cycle after reset. Required: scan is granted first; the engine burst starts the cycle after scan_ack+1; if both are re-raised, the next tie goes to scan only after an engine grant.
- Burst atomicity: scan_req raised during engine segment 3. Required: no scan strobe until eng_ack; scan is then granted.
- Reset mid-burst: rst_n = 0 during engine segment 4. Required: all outputs 0 next edge; no eng_ack; a new scan read succeeds after reset.
- Timeout (SRAM_ARB_TIMEOUT_EN): SRAM never asserts ready. Required: ack is pulsed after 64 WAIT cycles, arb_err = 1 and stays set, busy = 0 afterwards.
